vc_skid_queue_pf: RTL and testbench

Two-entry val/rdy skid queue built from positive-edge flip-flops. It is the registered stage between a producer and a consumer. It breaks every combinational path across the interface (data, valid and ready) while sustaining one message per cycle. This is the standard pipeline-boundary element for val/rdy-connected blocks that previously had to be connected with bare enable flip-flops.

---
 rtl/vc_skid_queue_pf.sv | 109 ++++++++++
 tb/tb_vc_skid_queue_pf.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vc_skid_queue_pf.sv
// vc_skid_queue_pf
//   Two-entry val/rdy skid queue placed between a producer and a consumer.
//   Every output is either a flop output or a decode of the occupancy
//   register, so no combinational path crosses the boundary in either
//   direction, yet one message per cycle is sustained while deq_rdy stays high.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset_n  : asynchronous active-low reset; clears occupancy and both entries
//   enq_val  : producer has a valid message
//   enq_rdy  : queue can accept a message this cycle (count != 2)
//   enq_msg  : producer message, captured only when enq_val && enq_rdy
//   deq_val  : head entry holds a valid message (count != 0)
//   deq_rdy  : consumer accepts the head this cycle
//   deq_msg  : head message (head register output)
//   count    : number of occupied entries, 0..2
module vc_skid_queue_pf #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_msg,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [W-1:0] deq_msg,
  output logic [1:0]   count
);

  // Occupancy doubles as the state; its encoding is the visible count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         enq_fire;
  logic         deq_fire;

  // Handshake outputs decode the occupancy register only.
  assign enq_rdy  = (state_q != FULL);
  assign deq_val  = (state_q != EMPTY);
  assign count    = state_q;
  assign deq_msg  = head_q;

  assign enq_fire = enq_val && enq_rdy;
  assign deq_fire = deq_val && deq_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (enq_fire) begin
          head_d  = enq_msg;
          state_d = ONE;
        end
      end
      ONE: begin
        if (enq_fire && deq_fire) begin
          // Head leaves and is replaced in the same edge; skid stays unused.
          head_d = enq_msg;
        end else if (enq_fire) begin
          skid_d  = enq_msg;
          state_d = FULL;
        end else if (deq_fire) begin
          // Head contents are left as-is; deq_val masks them.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deq_fire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

`ifndef SYNTHESIS
  a_enq_val_known: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown(enq_val));
  a_deq_rdy_known: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown(deq_rdy));
  a_count_range: assert property (@(posedge clk) disable iff (!reset_n)
    count != 2'd3);
`endif

endmodule

// File: tb/tb_vc_skid_queue_pf.sv
module tb_vc_skid_queue_pf;

  logic        clk;
  logic        reset_n;
  logic        enq_val;
  logic        enq_rdy;
  logic [31:0] enq_msg;
  logic        deq_val;
  logic        deq_rdy;
  logic [31:0] deq_msg;
  logic [1:0]  count;

  int errors = 0;
  int checks = 0;

  // Reference model: a bounded FIFO of at most two messages.
  logic [31:0] q[$];

  vc_skid_queue_pf #(.W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enq_val (enq_val),
    .enq_rdy (enq_rdy),
    .enq_msg (enq_msg),
    .deq_val (deq_val),
    .deq_rdy (deq_rdy),
    .deq_msg (deq_msg),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: fires are decided from the model's own occupancy.
  always @(posedge clk) begin
    if (reset_n) begin
      bit ef, df;
      ef = enq_val && (q.size() < 2);
      df = deq_rdy && (q.size() > 0);
      if (df) void'(q.pop_front());
      if (ef) q.push_back(enq_msg);
    end
  end

  always @(negedge reset_n) q.delete();

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("count", {30'd0, count}, q.size());
    chk("enq_rdy", {31'd0, enq_rdy}, {31'd0, q.size() < 2});
    chk("deq_val", {31'd0, deq_val}, {31'd0, q.size() > 0});
    if (!reset_n)
      chk("deq_msg_rst", deq_msg, 32'd0);
    else if (q.size() > 0)
      chk("deq_msg", deq_msg, q[0]);
  end

  // Apply inputs, then let one rising edge take them; returns 2 units after it.
  task automatic drive(input logic v, input logic [31:0] m, input logic r);
    enq_val = v;
    enq_msg = m;
    deq_rdy = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    enq_val = 1'b0;
    enq_msg = '0;
    deq_rdy = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_deq_val", {31'd0, deq_val}, 32'd0);
    chk("rst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    chk("rst_deq_msg", deq_msg, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // Idle
    repeat (3) drive(1'b0, 32'h0, 1'b0);
    chk("idle_count", {30'd0, count}, 32'd0);
    chk("idle_deq_msg", deq_msg, 32'd0);
    chk("idle_enq_rdy", {31'd0, enq_rdy}, 32'd1);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      if (i == 1) begin
        chk("stream_first_val", {31'd0, deq_val}, 32'd1);
        chk("stream_first_msg", deq_msg, 32'd1);
      end
    end
    chk("stream_last_msg", deq_msg, 32'd8);
    chk("stream_count", {30'd0, count}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);

    // Backpressure
    drive(1'b1, 32'hA, 1'b0);
    drive(1'b1, 32'hB, 1'b0);
    drive(1'b1, 32'hC, 1'b0);
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_enq_rdy", {31'd0, enq_rdy}, 32'd0);
    chk("bp_head", deq_msg, 32'hA);
    drive(1'b1, 32'hC, 1'b1);
    chk("bp_drain1", deq_msg, 32'hB);
    drive(1'b1, 32'hC, 1'b1);
    chk("bp_drain2", deq_msg, 32'hC);
    drive(1'b0, 32'h0, 1'b1);
    chk("bp_empty", {30'd0, count}, 32'd0);

    // Simultaneous enq/deq at count 1
    drive(1'b1, 32'h5, 1'b0);
    drive(1'b1, 32'h6, 1'b1);
    chk("sim_count", {30'd0, count}, 32'd1);
    chk("sim_msg", deq_msg, 32'h6);
    drive(1'b0, 32'h0, 1'b1);

    // Full drain with refill
    drive(1'b1, 32'h10, 1'b0);
    drive(1'b1, 32'h11, 1'b0);
    drive(1'b1, 32'h12, 1'b1);
    chk("refill1_count", {30'd0, count}, 32'd1);
    chk("refill1_msg", deq_msg, 32'h11);
    chk("refill1_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    drive(1'b1, 32'h12, 1'b1);
    chk("refill2_count", {30'd0, count}, 32'd1);
    chk("refill2_msg", deq_msg, 32'h12);
    drive(1'b0, 32'h0, 1'b1);

    // Async reset mid-stream
    drive(1'b1, 32'h20, 1'b0);
    drive(1'b1, 32'h21, 1'b0);
    chk("pre_rst_count", {30'd0, count}, 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_count", {30'd0, count}, 32'd0);
    chk("arst_deq_val", {31'd0, deq_val}, 32'd0);
    chk("arst_enq_rdy", {31'd0, enq_rdy}, 32'd1);
    chk("arst_deq_msg", deq_msg, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    drive(1'b1, 32'h77, 1'b0);
    chk("post_rst_msg", deq_msg, 32'h77);
    chk("post_rst_count", {30'd0, count}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0);
    chk("end_count", {30'd0, count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
